membus_arbiter: RTL
===================

MEMBUS_ARBITER -- requirements
Module: membus_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default eei::MEM_ADDR_WIDTH (16), memory address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default eei::MEM_DATA_WIDTH (64), memory data width.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 i_valid  in  1  fetch request valid.
REQ-006 i_ready  out  1  fetch request accepted this cycle.
REQ-007 i_addr  in  ADDR_WIDTH  fetch address.
REQ-008 i_rvalid  out  1  fetch response valid.
REQ-009 i_rdata  out  DATA_WIDTH  fetch read data.
REQ-010 d_valid  in  1  load/store request valid.
REQ-011 d_ready  out  1  load/store request accepted this cycle.
REQ-012 d_addr  in  ADDR_WIDTH  load/store address.
REQ-013 d_wen  in  1  1 = store, 0 = load.
REQ-014 d_wdata  in  DATA_WIDTH  store data.
REQ-015 d_wmask  in  DATA_WIDTH/8  store byte enables.
REQ-016 d_rvalid  out  1  load/store response valid (also returned for stores).
REQ-017 d_rdata  out  DATA_WIDTH  load data.
REQ-018 m_valid  out  1  memory request valid.
REQ-019 m_ready  in  1  memory accepts request.
REQ-020 m_addr  out  ADDR_WIDTH  memory address.
REQ-021 m_wen  out  1  memory write enable.
REQ-022 m_wdata  out  DATA_WIDTH  memory write data.
REQ-023 m_wmask  out  DATA_WIDTH/8  memory byte enables.
REQ-024 m_rvalid  in  1  memory response valid (one per accepted request, any latency >= 1).
REQ-025 m_rdata  in  DATA_WIDTH  memory read data.

Function
REQ-026 The block SHALL have states IDLE and BUSY, plus registers owner (FETCH/DATA) and last_grant (FETCH/DATA).
REQ-027 In IDLE the grant SHALL be: only one valid -> that one; both valid -> the requester not equal to last_grant; none -> no grant (m_valid=0).
REQ-028 In IDLE, m_valid/m_addr/m_wen/m_wdata/m_wmask SHALL combinationally mirror the granted requester; a fetch grant forces m_wen=0, m_wmask=0, m_wdata=0.
REQ-029 The granted requester's ready SHALL equal m_ready in IDLE; the non-granted ready SHALL be 0; both readies SHALL be 0 in BUSY.
REQ-030 On m_valid&m_ready in IDLE, the next state SHALL be BUSY, with owner and last_grant set to the grantee.
REQ-031 In BUSY, m_valid SHALL be 0 (one outstanding transaction maximum).
REQ-032 In BUSY, m_rvalid SHALL drive i_rvalid (owner=FETCH) or d_rvalid (owner=DATA) in the same cycle, and the next state SHALL be IDLE; the earliest next acceptance is the following cycle.
REQ-033 i_rdata and d_rdata SHALL equal m_rdata at all times; rvalid gating alone selects the destination.
REQ-034 m_rvalid in IDLE SHALL be ignored: no rvalid output, no state change.
REQ-035 Requesters hold valid and payload stable until ready; the block SHALL NOT latch the request payload.

Reset
REQ-036 While rst=0: state=IDLE, owner=FETCH, last_grant=FETCH; therefore the first simultaneous request goes to DATA.
REQ-037 Reset asserted mid-BUSY SHALL abandon the transaction; a late m_rvalid after reset SHALL be dropped per REQ-034.

Structure
REQ-038 Package membus_pkg (importing eei) SHALL hold typedef enum Owner {OWN_FETCH, OWN_DATA} and typedef enum ArbState {ST_IDLE, ST_BUSY}; widths come from eei.
REQ-039 The block SHALL be a single module with no sub-module; arbitration is inline combinational logic feeding two state registers.

Verification
REQ-040 Fetch only: i_addr=0x0100, m_ready=1, m_rvalid 2 cycles later with m_rdata=0x1122334455667788 -> i_ready pulses once, i_rvalid=1 with that data, d_rvalid stays 0.
REQ-041 Simultaneous after reset: i_valid=d_valid=1 -> DATA granted first; next accept -> FETCH; a third -> DATA (alternation).
REQ-042 Store: d_wen=1, d_addr=0x0200, d_wmask=0x0F, d_wdata=0xAA -> m_wen=1, m_wmask=0x0F; a later m_rvalid -> d_rvalid=1.
REQ-043 Backpressure: m_ready=0 for 3 cycles with i_valid=1 -> i_ready=0 throughout, state IDLE; then m_ready=1 -> single accept.
REQ-044 BUSY blocking: d_valid asserted during an outstanding fetch -> d_ready=0 and m_valid=0 until the cycle after m_rvalid.
REQ-045 Reset in BUSY, then a stray m_rvalid -> no i_rvalid or d_rvalid, and state stays IDLE.

Source files
------------

// File: rtl/eei_pkg.sv
// Execution-environment constants shared by the memory-side blocks.
package eei;
  localparam int MEM_ADDR_WIDTH = 16;
  localparam int MEM_DATA_WIDTH = 64;
endpackage

// File: rtl/membus_pkg.sv
// Types and default widths for the fetch/data memory bus arbiter.
package membus_pkg;
  import eei::*;

  localparam int ADDR_W = MEM_ADDR_WIDTH;
  localparam int DATA_W = MEM_DATA_WIDTH;

  typedef enum logic {OWN_FETCH, OWN_DATA} Owner;
  typedef enum logic {ST_IDLE, ST_BUSY} ArbState;
endpackage

// File: rtl/membus_arbiter_if.sv
// Bundles the fetch port, load/store port and shared memory port of the arbiter.
interface membus_arbiter_if #(
    parameter int ADDR_WIDTH = membus_pkg::ADDR_W,
    parameter int DATA_WIDTH = membus_pkg::DATA_W
);
    // Handshake: a request transfers in the cycle where valid and ready are both
    // high; the requester holds valid and payload stable until then. Responses
    // (rvalid) are single-cycle pulses with no back-pressure.
    logic                    i_valid;
    logic                    i_ready;
    logic [ADDR_WIDTH-1:0]   i_addr;
    logic                    i_rvalid;
    logic [DATA_WIDTH-1:0]   i_rdata;

    logic                    d_valid;
    logic                    d_ready;
    logic [ADDR_WIDTH-1:0]   d_addr;
    logic                    d_wen;
    logic [DATA_WIDTH-1:0]   d_wdata;
    logic [DATA_WIDTH/8-1:0] d_wmask;
    logic                    d_rvalid;
    logic [DATA_WIDTH-1:0]   d_rdata;

    logic                    m_valid;
    logic                    m_ready;
    logic [ADDR_WIDTH-1:0]   m_addr;
    logic                    m_wen;
    logic [DATA_WIDTH-1:0]   m_wdata;
    logic [DATA_WIDTH/8-1:0] m_wmask;
    logic                    m_rvalid;
    logic [DATA_WIDTH-1:0]   m_rdata;

    modport slave (
        input  i_valid, i_addr,
        output i_ready, i_rvalid, i_rdata,
        input  d_valid, d_addr, d_wen, d_wdata, d_wmask,
        output d_ready, d_rvalid, d_rdata,
        output m_valid, m_addr, m_wen, m_wdata, m_wmask,
        input  m_ready, m_rvalid, m_rdata
    );

    modport master (
        output i_valid, i_addr,
        input  i_ready, i_rvalid, i_rdata,
        output d_valid, d_addr, d_wen, d_wdata, d_wmask,
        input  d_ready, d_rvalid, d_rdata,
        input  m_valid, m_addr, m_wen, m_wdata, m_wmask,
        output m_ready, m_rvalid, m_rdata
    );
endinterface

// File: rtl/membus_arbiter.sv
// Two-requester memory arbiter: fetch vs load/store, one outstanding transaction,
// round-robin on simultaneous requests, request payload passed through unlatched.
module membus_arbiter
  import membus_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W,
    parameter int DATA_WIDTH = DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    membus_arbiter_if.slave   bus,
    output ArbState           dbg_state_o,
    output Owner              dbg_owner_o,
    output Owner              dbg_last_grant_o
);
    localparam int MASK_W = DATA_WIDTH / 8;

    ArbState state_q, state_d;
    Owner    owner_q, owner_d;
    Owner    last_grant_q, last_grant_d;

    logic    grant_any;
    Owner    grant;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_FETCH;
            last_grant_q <= OWN_FETCH;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
        end
    end

    // On a tie, whoever did not win last time gets the bus.
    always_comb begin
        grant_any = bus.i_valid | bus.d_valid;
        grant     = OWN_FETCH;
        if (bus.i_valid && bus.d_valid) begin
            grant = (last_grant_q == OWN_FETCH) ? OWN_DATA : OWN_FETCH;
        end else if (bus.d_valid) begin
            grant = OWN_DATA;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        bus.m_valid  = 1'b0;
        bus.m_addr   = {ADDR_WIDTH{1'b0}};
        bus.m_wen    = 1'b0;
        bus.m_wdata  = {DATA_WIDTH{1'b0}};
        bus.m_wmask  = {MASK_W{1'b0}};
        bus.i_ready  = 1'b0;
        bus.d_ready  = 1'b0;
        bus.i_rvalid = 1'b0;
        bus.d_rvalid = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    bus.m_valid = 1'b1;
                    if (grant == OWN_DATA) begin
                        bus.m_addr  = bus.d_addr;
                        bus.m_wen   = bus.d_wen;
                        bus.m_wdata = bus.d_wdata;
                        bus.m_wmask = bus.d_wmask;
                        bus.d_ready = bus.m_ready;
                    end else begin
                        bus.m_addr  = bus.i_addr;
                        bus.i_ready = bus.m_ready;
                    end
                    if (bus.m_ready) begin
                        state_d      = ST_BUSY;
                        owner_d      = grant;
                        last_grant_d = grant;
                    end
                end
            end
            ST_BUSY: begin
                if (bus.m_rvalid) begin
                    bus.i_rvalid = (owner_q == OWN_FETCH);
                    bus.d_rvalid = (owner_q == OWN_DATA);
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.i_rdata = bus.m_rdata;
    assign bus.d_rdata = bus.m_rdata;

    assign dbg_state_o      = state_q;
    assign dbg_owner_o      = owner_q;
    assign dbg_last_grant_o = last_grant_q;
endmodule
